// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage for the 4-bit ALU: buffers commands in a FIFO, reads
// operands from a 4-entry register file and writes ALU results back.
module alu_cmd_sequencer #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_rd,
    input  logic [1:0]        cmd_rs1,
    input  logic [1:0]        cmd_rs2,
    input  logic              issue_en,
    input  logic              hst_we,
    input  logic [1:0]        hst_addr,
    input  logic [DATA_W-1:0] hst_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = 9;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nx;

    logic [CW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [CW-1:0]     head;
    logic              push, pop, wb;
    logic [DATA_W-1:0] regs [4];
    logic [1:0]        rd_q;

    assign head      = fifo_mem[rd_ptr];
    assign cmd_ready = (count != (PW+1)'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state == EXEC) || (count != '0);
    assign dbg_data  = regs[dbg_addr];

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        wb       = 1'b0;
        case (state)
            IDLE: begin
                if (issue_en && (count != '0)) begin
                    pop      = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                wb       = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Storage is left unreset; only valid entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_rd, cmd_rs1, cmd_rs2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rd_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            rsp_valid <= wb;
            if (pop) begin
                alu_sel <= head[8:6];
                rd_q    <= head[5:4];
                alu_a   <= regs[head[3:2]];
                alu_b   <= regs[head[1:0]];
            end
            if (wb) begin
                rsp_data  <= alu_result;
                rsp_carry <= alu_carry;
                rsp_zero  <= alu_zero;
            end
        end
    end

    // Writeback has priority over a host write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (hst_we && !(wb && (hst_addr == rd_q))) begin
                regs[hst_addr] <= hst_data;
            end
            if (wb) begin
                regs[rd_q] <= alu_result;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU and
// a register-file reference model driven by randomized commands.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic       issue_en = 1'b1;
    logic       hst_we = 1'b0;
    logic [1:0] hst_addr = '0;
    logic [3:0] hst_data = '0;
    logic [1:0] dbg_addr = '0;
    logic [3:0] dbg_data, alu_a, alu_b, alu_result, rsp_data;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_zero, rsp_valid, rsp_carry, rsp_zero, busy;

    int checks = 0;
    int errors = 0;
    logic [3:0] mr [4];

    always #5 clk = ~clk;

    // Returns {carry, zero, result}
    function automatic logic [5:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int unsigned s;
        logic [3:0] r;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: begin s = a + b; r = s[3:0]; c = (s > 15); end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            default: begin r = {1'b0, a[3:1]}; c = a[0]; end
        endcase
        return {c, (r == 4'd0), r};
    endfunction

    assign {alu_carry, alu_zero, alu_result} = alu_ref(alu_sel, alu_a, alu_b);

    alu_cmd_sequencer #(.DATA_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .issue_en(issue_en), .hst_we(hst_we), .hst_addr(hst_addr), .hst_data(hst_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [3:0] d);
        hst_we = 1'b1; hst_addr = a; hst_data = d;
        tick();
        hst_we = 1'b0;
        mr[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== mr[i]) begin
                errors++;
                $display("FAIL %s reg%0d: got %0d expected %0d", tag, i, dbg_data, mr[i]);
            end
        end
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    endtask

    // Push one command with the sequencer idle and follow it through to its response.
    task automatic run_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        logic [5:0] e;
        e = alu_ref(op, mr[rs1], mr[rs2]);
        set_cmd(op, rd, rs1, rs2);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (alu_a !== mr[rs1] || alu_b !== mr[rs2] || alu_sel !== op || busy !== 1'b1) begin
            errors++;
            $display("FAIL operands: got a=%0d b=%0d sel=%0d busy=%b expected a=%0d b=%0d sel=%0d busy=1",
                     alu_a, alu_b, alu_sel, busy, mr[rs1], mr[rs2], op);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e[3:0] || rsp_zero !== e[4] || rsp_carry !== e[5]) begin
            errors++;
            $display("FAIL response op=%0d: got v=%b d=%0d c=%b z=%b expected v=1 d=%0d c=%b z=%b",
                     op, rsp_valid, rsp_data, rsp_carry, rsp_zero, e[3:0], e[5], e[4]);
        end
        mr[rd] = e[3:0];
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_end: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
        dbg_addr = rd;
        #1;
        checks++;
        if (dbg_data !== mr[rd]) begin
            errors++;
            $display("FAIL writeback r%0d: got %0d expected %0d", rd, dbg_data, mr[rd]);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 4'd0 ||
            rsp_carry !== 1'b0 || rsp_zero !== 1'b0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b busy=%b v=%b d=%0d a=%0d b=%0d sel=%0d expected 1 0 0 0 0 0 0",
                     cmd_ready, busy, rsp_valid, rsp_data, alu_a, alu_b, alu_sel);
        end
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        check_regs("reset");
    endtask

    task automatic test_add();
        host_write(2'd0, 4'd5);
        host_write(2'd1, 4'd3);
        run_op(3'd0, 2'd2, 2'd0, 2'd1);
    endtask

    task automatic test_carry_zero();
        host_write(2'd0, 4'd15);
        host_write(2'd1, 4'd15);
        run_op(3'd0, 2'd3, 2'd0, 2'd1);
        run_op(3'd4, 2'd2, 2'd0, 2'd0);
        check_regs("carry_zero");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last = -10;
        logic [3:0] v;
        host_write(2'd0, 4'd1);
        v = 4'd1;
        set_cmd(3'd0, 2'd0, 2'd0, 2'd0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            cmd_valid = (cyc < 3);
            tick();
            if (rsp_valid === 1'b1) begin
                v = v + v;
                checks++;
                if (rsp_data !== v || (pulses > 0 && cyc - last != 2)) begin
                    errors++;
                    $display("FAIL chain pulse%0d: got d=%0d spacing=%0d expected d=%0d spacing=2",
                             pulses, rsp_data, cyc - last, v);
                end
                last = cyc;
                pulses++;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL chain_count: got %0d expected 3", pulses);
        end
        mr[0] = 4'd8;
        check_regs("chain");
    endtask

    task automatic test_full();
        logic [8:0] q[$];
        logic [8:0] c;
        logic [5:0] e;
        int pulses = 0;
        issue_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = 9'($urandom);
            set_cmd(c[8:6], c[5:4], c[3:2], c[1:0]);
            cmd_valid = 1'b1;
            #1;
            checks++;
            if (cmd_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready push%0d: got %b expected %b", i, cmd_ready, (i < 4));
            end
            if (i < 4) q.push_back(c);
            tick();
        end
        cmd_valid = 1'b0;
        issue_en = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_pop: got %b expected 1", cmd_ready);
        end
        for (int cyc = 0; cyc < 20 && pulses < 6; cyc++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL full_extra_rsp: got d=%0d expected none", rsp_data);
                end else begin
                    c = q.pop_front();
                    e = alu_ref(c[8:6], mr[c[3:2]], mr[c[1:0]]);
                    mr[c[5:4]] = e[3:0];
                    if (rsp_data !== e[3:0] || rsp_carry !== e[5] || rsp_zero !== e[4]) begin
                        errors++;
                        $display("FAIL full_rsp%0d: got d=%0d c=%b z=%b expected d=%0d c=%b z=%b",
                                 pulses, rsp_data, rsp_carry, rsp_zero, e[3:0], e[5], e[4]);
                    end
                end
                pulses++;
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL full_count: got %0d expected 4", pulses);
        end
        check_regs("full");
    endtask

    task automatic test_collision();
        logic [3:0] d;
        host_write(2'd0, 4'd5);
        host_write(2'd1, 4'd3);
        set_cmd(3'd0, 2'd2, 2'd0, 2'd1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        hst_we = 1'b1; hst_addr = 2'd2; hst_data = 4'd9;
        tick();
        hst_we = 1'b0;
        mr[2] = 4'd8;
        tick();
        d = 4'($urandom);
        set_cmd(3'd3, 2'd3, 2'd0, 2'd1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        hst_we = 1'b1; hst_addr = 2'd1; hst_data = d;
        tick();
        hst_we = 1'b0;
        mr[3] = 4'd7;
        mr[1] = d;
        tick();
        check_regs("collision");
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) host_write(2'($urandom), 4'($urandom));
            run_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end
        check_regs("random");
    endtask

    task automatic test_reset_mid_exec();
        int seen = 0;
        host_write(2'd0, 4'd7);
        host_write(2'd1, 4'd6);
        set_cmd(3'd0, 2'd2, 2'd0, 2'd1);
        cmd_valid = 1'b1;
        tick();
        set_cmd(3'd1, 2'd3, 2'd0, 2'd1);
        tick();
        cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_sel !== 3'd0 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got a=%0d b=%0d sel=%0d ready=%b busy=%b v=%b expected 0 0 0 1 0 0",
                     alu_a, alu_b, alu_sel, cmd_ready, busy, rsp_valid);
        end
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_discard: got %0d cycles with rsp_valid/busy expected 0", seen);
        end
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        check_regs("reset_mid_exec");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_add();
        test_carry_zero();
        test_back_to_back();
        test_full();
        test_collision();
        test_random();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-issue stage that sits directly upstream of the 4-bit ALU (alu4bit) and feeds it.
- Buffers incoming ALU commands in a small FIFO and holds a 4-entry x 4-bit register file.
- Drives the ALU's a/b/sel inputs from the register file, captures result/carry/zero, writes the result back to the register file and emits a one-cycle response pulse.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU.
- FIFO_DEPTH, 4, command FIFO depth; power of 2, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full; a command is accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  3  ALU select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LSHIFT, 111 RSHIFT.
- cmd_rd  in  2  destination register.
- cmd_rs1  in  2  source register driven on alu_a.
- cmd_rs2  in  2  source register driven on alu_b.
- issue_en  in  1  when 0, no new command is popped; an in-flight op still completes.
- hst_we  in  1  host register write enable.
- hst_addr  in  2  host write address.
- hst_data  in  DATA_W  host write data.
- dbg_addr  in  2  register-file read address.
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr].
- alu_a  out  DATA_W  registered operand a to the ALU.
- alu_b  out  DATA_W  registered operand b to the ALU.
- alu_sel  out  3  registered op select to the ALU.
- alu_result  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  one-cycle pulse: op completed.
- rsp_data  out  DATA_W  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zero  out  1  captured zero flag.
- busy  out  1  high when the FSM is in EXEC or the FIFO is non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; cmd_ready=1.
  - All four registers = 0.
  - alu_a/alu_b/alu_sel = 0.
  - rsp_valid/rsp_data/rsp_carry/rsp_zero = 0.
  - FSM = IDLE; busy = 0.
- FSM has two states, IDLE and EXEC.
  - IDLE, FIFO non-empty and issue_en=1, at edge En:
    - pop the FIFO head;
    - load alu_a=reg[rs1], alu_b=reg[rs2], alu_sel=op;
    - latch rd;
    - go to EXEC.
  - EXEC: the ALU evaluates combinationally. At edge En+1:
    - reg[rd] <= alu_result;
    - rsp_data/carry/zero <= ALU outputs;
    - rsp_valid=1 for exactly the cycle after En+1;
    - go to IDLE.
  - Issue-to-response latency is 2 edges. Throughput is 1 op per 2 cycles.
  - The next pop happens at the earliest on En+2, so back-to-back ops always read the written-back value (no hazard logic).
- alu_a/alu_b/alu_sel hold their last values outside EXEC.
- The sequencer does not interpret carry/zero; it passes them through as produced by the ALU.
- FIFO:
  - In-order.
  - A push and a pop on the same edge are both honoured; the count is unchanged.
  - When full, cmd_ready=0 and the push is ignored.
  - A command pushed at edge E is poppable no earlier than E+1.
  - Pointers wrap modulo FIFO_DEPTH.
- Host write:
  - reg[hst_addr] <= hst_data when hst_we=1.
  - If it collides with an EXEC writeback to the same address on the same edge, the writeback wins and the host write is dropped.
  - A host write to a different address proceeds.
- issue_en falling during EXEC does not abort the op.
- Reset asserted mid-EXEC:
  - the op is discarded;
  - no rsp_valid;
  - no writeback;
  - FIFO contents are lost.
- rsp_valid has no backpressure; the consumer must sample it in the pulse cycle.

Test Plan (bench instantiates alu4bit wired to the alu_* ports):
- Host-write r0=5, r1=3; cmd ADD rd=2 rs1=0 rs2=1 -> during EXEC alu_a=5, alu_b=3, alu_sel=000; rsp_valid pulse with rsp_data=8, rsp_carry=0, rsp_zero=0; dbg_data(r2)=8.
- r0=15, r1=15; cmd ADD rd=3 rs1=0 rs2=1 -> rsp_data=4'b1110, rsp_carry=1; then cmd XOR rd=2 rs1=0 rs2=0 -> rsp_data=0, rsp_zero=1, r2=0.
- Dependent chain r0=1: ADD rd=0 rs1=0 rs2=0, issued three times back-to-back -> rsp_data 2, 4, 8 on pulses spaced 2 cycles apart; final r0=8.
- issue_en=0, push 5 commands -> first 4 accepted, cmd_ready=0 on the 5th and it is not accepted; raise issue_en -> 4 rsp pulses in push order; cmd_ready returns to 1 after the first pop.
- Writeback to r2 with hst_we=1, hst_addr=2, hst_data=9 on the same edge -> r2 holds the ALU result, not 9; a host write to r1 on the same edge lands.
- Assert rst_n=0 during EXEC -> no rsp_valid; all registers 0; cmd_ready=1; alu_a/alu_b/alu_sel=0 immediately, without waiting for a clock edge.
